// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and sizing helpers for the FIFO read-side packer.
package fifo_rd_packer_pkg;

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    // Lane-index width, $clog2(lanes), floored at one bit so a slice stays legal.
    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_lane_reg.sv
// One packed-word lane: a data register plus its keep bit.
module fifo_rd_lane_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             keep_o
);

    logic [WIDTH-1:0] data_q;
    logic             keep_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            keep_q <= 1'b0;
        end else if (clr_i) begin
            data_q <= '0;
            keep_q <= 1'b0;
        end else if (we_i) begin
            data_q <= data_i;
            keep_q <= 1'b1;
        end
    end

    assign data_o = data_q;
    assign keep_o = keep_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO words into LANES-wide output words; flush emits a partial word.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk_rd_i,
    input  logic                   rst_ni,
    input  logic                   empty_i,
    output logic                   rd_en_o,
    input  logic [WIDTH-1:0]       rdata_i,
    input  logic                   flush_i,
    output logic [WIDTH*LANES-1:0] out_data_o,
    output logic [LANES-1:0]       out_keep_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [15:0]            word_cnt_o
);

    localparam int unsigned     IdxW   = lane_idx_w(LANES);
    localparam int unsigned     CntW   = IdxW + 1;
    localparam logic [CntW-1:0] LanesC = CntW'(LANES);
    localparam logic [CntW-1:0] LastC  = CntW'(LANES - 1);
    localparam logic [CntW-1:0] OneC   = CntW'(1);

    state_e          state_q, state_d;
    logic [CntW-1:0] issue_q, issue_d;
    logic [CntW-1:0] fill_q, fill_d;
    logic [15:0]     word_cnt_q, word_cnt_d;
    logic            pend_q;
    logic            run_q;
    logic            capture;
    logic            xfer;
    logic            flush_ok;

    always_comb begin
        state_d    = state_q;
        issue_d    = issue_q;
        fill_d     = fill_q;
        word_cnt_d = word_cnt_q;
        rd_en_o    = 1'b0;
        capture    = pend_q;
        xfer       = 1'b0;
        flush_ok   = 1'b0;
        case (state_q)
            StFill: begin
                // run_q holds off pops until the first edge after reset release.
                rd_en_o  = run_q && !empty_i && (issue_q < LanesC);
                // A pop issued now or landing now makes the partial word incomplete.
                flush_ok = flush_i && (fill_q != '0) && !pend_q && !rd_en_o;
                if (rd_en_o) begin
                    issue_d = issue_q + OneC;
                end
                if (capture) begin
                    fill_d = fill_q + OneC;
                end
                if ((capture && (fill_q == LastC)) || flush_ok) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    xfer       = 1'b1;
                    state_d    = StFill;
                    issue_d    = '0;
                    fill_d     = '0;
                    word_cnt_d = word_cnt_q + 16'd1;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk_rd_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StFill;
            issue_q    <= '0;
            fill_q     <= '0;
            word_cnt_q <= '0;
            pend_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            issue_q    <= issue_d;
            fill_q     <= fill_d;
            word_cnt_q <= word_cnt_d;
            pend_q     <= rd_en_o;
            run_q      <= 1'b1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fifo_rd_lane_reg #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk_i  (clk_rd_i),
            .rst_ni (rst_ni),
            .clr_i  (xfer),
            .we_i   (capture && (fill_q[IdxW-1:0] == IdxW'(i))),
            .data_i (rdata_i),
            .data_o (out_data_o[i*WIDTH +: WIDTH]),
            .keep_o (out_keep_o[i])
        );
    end

    assign out_valid_o = (state_q == StHold);
    assign word_cnt_o  = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Packer fed by a dual-clock gray-pointer FIFO; outputs checked against a byte-queue model.
module tb_fifo_rd_packer;

    logic        clk_wr = 1'b0;
    logic        clk_rd;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wdata;
    logic        empty;
    logic        full;
    logic        rd_en;
    logic [7:0]  rdata;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_cnt;
    logic        underflow;

    int errors = 0;
    int checks = 0;

    fifo_rd_packer #(
        .WIDTH (8),
        .LANES (4)
    ) dut (
        .clk_rd_i    (clk_rd),
        .rst_ni      (rst_n),
        .empty_i     (empty),
        .rd_en_o     (rd_en),
        .rdata_i     (rdata),
        .flush_i     (flush),
        .out_data_o  (out_data),
        .out_keep_o  (out_keep),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .word_cnt_o  (word_cnt)
    );

    always #4 clk_wr = ~clk_wr;
    initial begin
        clk_rd = 1'b0;
        forever begin
            #3 clk_rd = 1'b1;
            #2 clk_rd = 1'b0;
        end
    end

    // Async FIFO, WIDTH=8 DEPTH=8, gray pointers through two-flop synchronisers.
    logic [7:0] mem [8];
    logic [3:0] wbin_q, rbin_q, rg_s1, rg_s2, wg_s1, wg_s2;

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    assign full  = (b2g(wbin_q) == {~rg_s2[3:2], rg_s2[1:0]});
    assign empty = (b2g(rbin_q) == wg_s2);

    always @(posedge clk_wr or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q <= '0;
            rg_s1  <= '0;
            rg_s2  <= '0;
        end else begin
            rg_s1 <= b2g(rbin_q);
            rg_s2 <= rg_s1;
            if (wr_en && !full) begin
                mem[wbin_q[2:0]] <= wdata;
                wbin_q <= wbin_q + 4'd1;
            end
        end
    end

    always @(posedge clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            rbin_q    <= '0;
            wg_s1     <= '0;
            wg_s2     <= '0;
            rdata     <= '0;
            underflow <= 1'b0;
        end else begin
            wg_s1 <= b2g(wbin_q);
            wg_s2 <= wg_s1;
            if (rd_en) begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    rdata  <= mem[rbin_q[2:0]];
                    rbin_q <= rbin_q + 4'd1;
                end
            end
        end
    end

    // Monitor: records every accepted word and any pop requested while empty.
    logic [35:0] got_q[$];
    int          rd_empty_n = 0;

    always @(negedge clk_rd) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back({out_keep, out_data});
            if (rd_en && empty) rd_empty_n++;
        end
    end

    // Reference model: bytes written but not yet packed, and the words they must form.
    logic [7:0]  bq[$];
    logic [35:0] exp_q[$];
    logic [15:0] exp_cnt = '0;
    int          ci = 0;
    bit          push_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_rd);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk_wr);
        wr_en = 1'b1;
        wdata = b;
        bq.push_back(b);
        @(posedge clk_wr);
        #1 wr_en = 1'b0;
    endtask

    task automatic emit(input int n);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = bq.pop_front();
        exp_q.push_back({4'((1 << n) - 1), d});
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic pulse_flush();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_got(input string tag, input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 400) begin
            @(negedge clk_rd);
            k++;
        end
        chk(tag, 64'(got_q.size() >= n), 64'd1);
    endtask

    task automatic compare(input string tag);
        logic [35:0] g;
        while (ci < exp_q.size()) begin
            g = (ci < got_q.size()) ? got_q[ci] : 'x;
            chk(tag, 64'(g), 64'(exp_q[ci]));
            ci++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_keep"}, 64'(out_keep), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_cnt"}, 64'(word_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int n;
        int rem;
        logic [35:0] held;
        int bad;

        rst_n = 1'b0; wr_en = 1'b0; wdata = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk_rd);
        @(negedge clk_rd);
        chk_zero("reset");
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Eight sequential bytes form two full words.
        for (int i = 1; i <= 8; i++) push(8'(i));
        emit(4);
        emit(4);
        wait_got("seq8_wait", 2);
        chk("seq8_word0", 64'(got_q[0]), 64'({4'hF, 32'h04030201}));
        chk("seq8_word1", 64'(got_q[1]), 64'({4'hF, 32'h08070605}));
        compare("seq8_model");
        @(negedge clk_rd);
        chk("seq8_cnt", 64'(word_cnt), 64'(exp_cnt));
        chk("seq8_underflow", 64'(underflow), 64'd0);

        // Flush with nothing filled is dropped and must not linger.
        pulse_flush();
        @(negedge clk_rd);
        chk("flush_idle_ignored", 64'(out_valid), 64'd0);

        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        k = 0;
        while (out_keep !== 4'h7 && k < 200) begin
            @(negedge clk_rd);
            k++;
        end
        chk("part_fill_wait", 64'(k < 200), 64'd1);
        chk("part_not_queued", 64'(out_valid), 64'd0);
        repeat (2) step();
        pulse_flush();
        emit(3);
        wait_got("part_wait", 3);
        chk("part_word", 64'(got_q[2]), 64'({4'h7, 32'h00CCBBAA}));
        compare("part_model");

        // Backpressure: word must hold while spare bytes sit in the FIFO.
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'($urandom));
        emit(4);
        k = 0;
        while (out_valid !== 1'b1 && k < 200) begin
            @(negedge clk_rd);
            k++;
        end
        chk("hold_wait", 64'(k < 200), 64'd1);
        chk("hold_word", 64'({out_keep, out_data}), 64'(exp_q[exp_q.size()-1]));
        held = {out_keep, out_data};
        bad = 0;
        repeat (10) begin
            @(negedge clk_rd);
            if (out_valid !== 1'b1 || {out_keep, out_data} !== held || rd_en !== 1'b0) bad++;
        end
        chk("hold_stable", 64'(bad), 64'd0);
        chk("hold_fifo_has_data", 64'(empty), 64'd0);
        step();
        out_ready = 1'b1;
        wait_got("hold_xfer_wait", 4);
        compare("hold_xfer");
        push(8'($urandom));
        push(8'($urandom));
        emit(4);
        wait_got("hold_next_wait", 5);
        compare("hold_next");

        // Reset part-way through a word discards the partial lanes.
        push_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) push(8'($urandom));
                push_done = 1'b1;
            end
        join_none
        k = 0;
        while (out_keep !== 4'h3 && k < 200) begin
            @(negedge clk_rd);
            k++;
        end
        chk("rst_mid_wait", 64'(k < 200), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        k = 0;
        while (!push_done && k < 100) begin
            @(negedge clk_rd);
            k++;
        end
        bq.delete();
        exp_cnt = '0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        emit(4);
        wait_got("post_rst_wait", exp_q.size());
        compare("post_rst_word");
        @(negedge clk_rd);
        chk("post_rst_cnt", 64'(word_cnt), 64'(exp_cnt));

        // Counter wrap from a preloaded FFFE.
        step();
        force dut.word_cnt_d = 16'hFFFE;
        step();
        release dut.word_cnt_d;
        exp_cnt = 16'hFFFE;
        @(negedge clk_rd);
        chk("wrap_preload", 64'(word_cnt), 64'hFFFE);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 4; i++) push(8'($urandom));
            emit(4);
            wait_got("wrap_wait", exp_q.size());
            compare("wrap_word");
            @(negedge clk_rd);
            chk("wrap_cnt", 64'(word_cnt), 64'(exp_cnt));
        end
        chk("wrap_final_0001", 64'(exp_cnt), 64'h0001);

        // Random batch lengths; any leftover lanes are flushed out.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 8);
            rem = n % 4;
            for (int i = 0; i < n; i++) push(8'($urandom));
            for (int g = 0; g < n / 4; g++) emit(4);
            if (rem != 0) begin
                k = 0;
                while (!(got_q.size() == exp_q.size() && out_valid === 1'b0 &&
                         out_keep === 4'((1 << rem) - 1)) && k < 300) begin
                    @(negedge clk_rd);
                    k++;
                end
                chk("rnd_fill_wait", 64'(k < 300), 64'd1);
                repeat (2) step();
                pulse_flush();
                emit(rem);
            end
            wait_got("rnd_wait", exp_q.size());
            compare("rnd_word");
        end
        @(negedge clk_rd);
        chk("final_cnt", 64'(word_cnt), 64'(exp_cnt));
        chk("final_transfers", 64'(got_q.size()), 64'(exp_q.size()));
        chk("final_rd_en_while_empty", 64'(rd_empty_n), 64'd0);
        chk("final_underflow", 64'(underflow), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
